// File: rtl/pipelined_carry_skip_addsub.sv
// pipelined_carry_skip_addsub: pipelined carry-skip adder/subtractor with flags, tag and valid/ready flow control
module pipelined_carry_skip_addsub #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4,
  parameter int BPS   = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [TAG_W-1:0] tag_out
);
  localparam int SW   = BLOCK * BPS;
  localparam int NSTG = WIDTH / SW;
  logic [NSTG-1:0]  v, en, vin, cr, nc, ic;
  logic [WIDTH-1:0] ar [NSTG];
  logic [WIDTH-1:0] br [NSTG];
  logic [WIDTH-1:0] sr [NSTG];
  logic [WIDTH-1:0] ia [NSTG];
  logic [WIDTH-1:0] ib [NSTG];
  logic [WIDTH-1:0] is [NSTG];
  logic [WIDTH-1:0] ns [NSTG];
  logic [TAG_W-1:0] tr [NSTG];
  logic [TAG_W-1:0] it [NSTG];
  logic             ov, zr, nov, nzr, c, bc, pp, pb, cm;
  // stall chain: a stage loads when empty or when its successor drains this cycle
  always_comb begin
    en[NSTG-1] = !v[NSTG-1] || out_ready;
    for (int k = NSTG - 2; k >= 0; k--) en[k] = !v[k] || en[k+1];
  end
  // stage inputs: stage 0 from the ports (b pre-inverted for subtract), later stages from the previous register
  always_comb begin
    ia[0]  = a;
    ib[0]  = b ^ {WIDTH{sub}};
    is[0]  = '0;
    ic[0]  = cin ^ sub;
    it[0]  = tag;
    vin[0] = in_valid;
    for (int k = 1; k < NSTG; k++) begin
      ia[k]  = ar[k-1];
      ib[k]  = br[k-1];
      is[k]  = sr[k-1];
      ic[k]  = cr[k-1];
      it[k]  = tr[k-1];
      vin[k] = v[k-1];
    end
  end
  // per-stage carry-skip slice: ripple within a block, skip the block carry when all bits propagate
  always_comb begin
    c   = 1'b0;
    bc  = 1'b0;
    pp  = 1'b0;
    pb  = 1'b0;
    cm  = 1'b0;
    for (int k = 0; k < NSTG; k++) begin
      ns[k] = is[k];
      c     = ic[k];
      for (int j = 0; j < BPS; j++) begin
        bc = c;
        pb = 1'b1;
        for (int i = 0; i < BLOCK; i++) begin
          pp = ia[k][k*SW + j*BLOCK + i] ^ ib[k][k*SW + j*BLOCK + i];
          ns[k][k*SW + j*BLOCK + i] = pp ^ c;
          cm = (k*SW + j*BLOCK + i == WIDTH - 1) ? c : cm;
          c  = (ia[k][k*SW + j*BLOCK + i] & ib[k][k*SW + j*BLOCK + i]) | (pp & c);
          pb = pb & pp;
        end
        c = pb ? bc : c;
      end
      nc[k] = c;
    end
    nov = cm ^ nc[NSTG-1];
    nzr = ns[NSTG-1] == '0;
  end
  // stage registers: valid moves on every enabled edge, payload only when a real operation arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      v  <= '0;
      cr <= '0;
      ov <= 1'b0;
      zr <= 1'b0;
      for (int k = 0; k < NSTG; k++) begin
        ar[k] <= '0;
        br[k] <= '0;
        sr[k] <= '0;
        tr[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NSTG; k++) begin
        if (en[k]) v[k] <= vin[k];
        if (en[k] && vin[k]) begin
          ar[k] <= ia[k];
          br[k] <= ib[k];
          sr[k] <= ns[k];
          cr[k] <= nc[k];
          tr[k] <= it[k];
        end
      end
      if (en[NSTG-1] && vin[NSTG-1]) begin
        ov <= nov;
        zr <= nzr;
      end
    end
  end
  assign in_ready  = en[0];
  assign out_valid = v[NSTG-1];
  assign sum       = sr[NSTG-1];
  assign cout      = cr[NSTG-1];
  assign tag_out   = tr[NSTG-1];
  assign ovf       = ov;
  assign zero      = zr;
endmodule

// File: tb/tb_pipelined_carry_skip_addsub.sv
// tb_pipelined_carry_skip_addsub: directed and randomized checks against an arithmetic reference model
module tb_pipelined_carry_skip_addsub;
  localparam int W = 16, NS = 4;
  logic          clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
  logic          out_valid, out_ready = 1'b1, cout, ovf, zero;
  logic [W-1:0]  a = '0, b = '0, sum;
  logic [3:0]    tag = '0, tag_out;
  logic [22:0]   q[$];
  logic [22:0]   prev_out;
  logic          prev_stall = 1'b0, acc;
  int            passed = 0, total = 0, n, sent;
  pipelined_carry_skip_addsub #(.WIDTH(W), .BLOCK(4), .BPS(1), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .sub(sub), .tag(tag), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .ovf(ovf), .zero(zero), .tag_out(tag_out));
  always #5 clk = ~clk;
  function automatic logic [22:0] model(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic sb, logic [3:0] t);
    logic [W:0] r;
    int sx, sy, s;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (sb) begin
      r = {1'b0, x} + {1'b0, ~y} + {16'd0, !ci};
      s = sx - sy - int'(ci);
    end else begin
      r = {1'b0, x} + {1'b0, y} + {16'd0, ci};
      s = sx + sy + int'(ci);
    end
    return {r[W-1:0], r[W], (s > 32767 || s < -32768), r[W-1:0] == '0, t};
  endfunction
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%h exp=%h", name, got, exp);
  endtask
  // one cycle: settle, score the handshake about to happen, then advance past the edge
  task automatic step();
    #1;
    acc = 1'b0;
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("hold", {9'd0, sum, cout, ovf, zero, tag_out}, {9'd0, prev_out});
      chk("in_ready", {31'd0, in_ready}, {31'd0, !(q.size() == NS && !out_ready)});
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious", 32'd1, 32'd0);
        else chk("result", {9'd0, sum, cout, ovf, zero, tag_out}, {9'd0, q.pop_front()});
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, cin, sub, tag));
        acc = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev_out = {sum, cout, ovf, zero, tag_out};
    end
    @(posedge clk);
    #1;
  endtask
  task automatic dir(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic sb, logic [3:0] t, logic [22:0] e);
    a = x; b = y; cin = ci; sub = sb; tag = t; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk("latency", n, NS);
    chk("directed", {9'd0, sum, cout, ovf, zero, tag_out}, {9'd0, e});
  endtask
  initial begin
    repeat (2) step();
    rst = 1'b0;
    chk("rst_out", {8'd0, out_valid, sum, cout, ovf, zero, tag_out}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    dir(16'h00FF, 16'h0001, 1'b0, 1'b0, 4'd3, {16'h0100, 1'b0, 1'b0, 1'b0, 4'd3});
    dir(16'hFFFF, 16'h0000, 1'b1, 1'b0, 4'd5, {16'h0000, 1'b1, 1'b0, 1'b1, 4'd5});
    dir(16'h8000, 16'h0001, 1'b0, 1'b1, 4'd7, {16'h7FFF, 1'b1, 1'b1, 1'b0, 4'd7});
    dir(16'h0003, 16'h0005, 1'b0, 1'b1, 4'd9, {16'hFFFE, 1'b0, 1'b0, 1'b0, 4'd9});
    dir(16'h7FFF, 16'h0000, 1'b1, 1'b0, 4'd2, {16'h8000, 1'b0, 1'b1, 1'b0, 4'd2});
    dir(16'h1234, 16'h1234, 1'b0, 1'b1, 4'd1, {16'h0000, 1'b1, 1'b0, 1'b1, 4'd1});
    sent = 0;
    n = 0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom); tag = 4'($urandom);
    while (sent < 20 && n < 500) begin
      in_valid = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      step();
      n++;
      if (acc) begin
        sent++;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom); tag = 4'($urandom);
      end
    end
    chk("sent", sent, 20);
    in_valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    chk("drained", q.size(), 0);
    out_ready = 1'b1;
    repeat (2) step();
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 4) && (i % 2 == 0);
      a = 16'($urandom); b = 16'($urandom); tag = 4'(i);
      #1;
      chk("bubble", {31'd0, out_valid}, {31'd0, (i == 4 || i == 6)});
      step();
    end
    in_valid = 1'b1;
    repeat (3) begin
      a = 16'($urandom); b = 16'($urandom);
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_out", {8'd0, out_valid, sum, cout, ovf, zero, tag_out}, 32'd0);
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("stale", {31'd0, out_valid}, 32'd0);
      step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
